// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: latches an ALU request, enables one unit for EXEC_CYCLES, then captures result and flags
module alu_op_sequencer #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic       A0,
  input  logic       A1,
  input  logic       A2,
  input  logic       A3,
  input  logic       B0,
  input  logic       B1,
  input  logic       B2,
  input  logic       B3,
  output logic       OA0,
  output logic       OA1,
  output logic       OA2,
  output logic       OA3,
  output logic       OB0,
  output logic       OB1,
  output logic       OB2,
  output logic       OB3,
  output logic       and_en,
  output logic       or_en,
  output logic       xor_en,
  output logic       add_en,
  output logic       sub_en,
  output logic       not_en,
  input  logic       R0,
  input  logic       R1,
  input  logic       R2,
  input  logic       R3,
  input  logic       carry_in,
  output logic       Y0,
  output logic       Y1,
  output logic       Y2,
  output logic       Y3,
  output logic       carry_out,
  output logic       zero,
  output logic       busy,
  output logic       done,
  output logic       illegal
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, oa, ob, y, a, b, r;
  logic [2:0] op;
  logic ill, cy, zr, legal, accept, exec;
  assign a = {A3, A2, A1, A0};
  assign b = {B3, B2, B1, B0};
  assign r = {R3, R2, R1, R0};
  assign legal = opcode < 3'd5;
  assign accept = state == IDLE && start;
  assign exec = state == EXEC;
  // next state: idle waits for a request, exec runs until the counter empties, done always returns to idle
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (start ? (legal ? EXEC : DONE) : IDLE)
             : exec ? (cnt == 4'd0 ? DONE : EXEC) : IDLE;
  end
  // state, operand latch, cycle counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      ill <= 1'b0;
      oa <= '0;
      ob <= '0;
      y <= '0;
      cy <= 1'b0;
      zr <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        ill <= !legal;
        if (legal) begin
          oa <= a;
          ob <= b;
          op <= opcode;
          cnt <= 4'(EXEC_CYCLES - 1);
        end
      end
      if (exec && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (exec && cnt == 4'd0) begin
        y <= r;
        zr <= r == 4'd0;
        cy <= (op == 3'd3 || op == 3'd4) && carry_in;
      end
    end
  end
  assign {OA3, OA2, OA1, OA0} = oa;
  assign {OB3, OB2, OB1, OB0} = ob;
  assign {Y3, Y2, Y1, Y0} = y;
  assign carry_out = cy;
  assign zero = zr;
  assign and_en = exec && op == 3'd0;
  assign or_en  = exec && op == 3'd1;
  assign xor_en = exec && op == 3'd2;
  assign add_en = exec && op == 3'd3;
  assign sub_en = exec && op == 3'd4;
  assign not_en = exec && op == 3'd5;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign illegal = done && ill;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: three sequencers (1, 3 and 4 exec cycles) checked against a cycle-count transaction model
module tb_alu_op_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b1;
  logic [2:0] opcode = 3'd1;
  logic [3:0] a = '0, b = '0;
  logic [2:0][22:0] obs;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  function automatic logic [4:0] alu_ref(input logic [3:0] x, input logic [3:0] z, input logic [2:0] o);
    logic [4:0] s, d;
    s = {1'b0, x} + {1'b0, z};
    d = {1'b0, x} - {1'b0, z};
    case (o)
      3'd0: return {1'b0, x & z};
      3'd1: return {1'b0, x | z};
      3'd2: return {1'b0, x ^ z};
      3'd3: return s;
      3'd4: return d;
      default: return {1'b0, ~x};
    endcase
  endfunction

  task automatic check(input string nm, input logic [22:0] got, input logic [22:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int EC = g == 0 ? 1 : g == 1 ? 3 : 4;
    logic [3:0] oa, ob, y, r;
    logic ae, oe, xe, de, se, ne, ci, cy, z, busy, done, ill;
    logic [4:0] s, df;
    assign s = {1'b0, oa} + {1'b0, ob};
    assign df = {1'b0, oa} - {1'b0, ob};
    assign r = ({4{ae}} & (oa & ob)) | ({4{oe}} & (oa | ob)) | ({4{xe}} & (oa ^ ob))
             | ({4{de}} & s[3:0]) | ({4{se}} & df[3:0]) | ({4{ne}} & ~oa);
    assign ci = (de & s[4]) | (se & df[4]);
    assign obs[g] = {oa, ob, ae, oe, xe, de, se, ne, y, cy, z, busy, done, ill};

    alu_op_sequencer #(.EXEC_CYCLES(EC)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode),
      .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]),
      .B0(b[0]), .B1(b[1]), .B2(b[2]), .B3(b[3]),
      .OA0(oa[0]), .OA1(oa[1]), .OA2(oa[2]), .OA3(oa[3]),
      .OB0(ob[0]), .OB1(ob[1]), .OB2(ob[2]), .OB3(ob[3]),
      .and_en(ae), .or_en(oe), .xor_en(xe), .add_en(de), .sub_en(se), .not_en(ne),
      .R0(r[0]), .R1(r[1]), .R2(r[2]), .R3(r[3]), .carry_in(ci),
      .Y0(y[0]), .Y1(y[1]), .Y2(y[2]), .Y3(y[3]),
      .carry_out(cy), .zero(z), .busy(busy), .done(done), .illegal(ill)
    );

    // d counts edges since acceptance: enable for d < EC, done at d == EC (illegal: done at d == 0)
    int d = 0;
    logic act = 1'b0, leg = 1'b0, mc = 1'b0, mz = 1'b0;
    logic [3:0] ma = '0, mb = '0, my = '0;
    logic [2:0] mo = '0;
    initial forever begin
      logic idle0;
      logic [4:0] res;
      logic [5:0] en;
      @(negedge clk);
      en = (act && leg && d < EC) ? 6'b100000 >> mo : 6'b000000;
      check($sformatf("cycle u%0d", g), obs[g],
            {ma, mb, en, my, mc, mz, act, act && (leg ? d == EC : 1'b1), act && !leg});
      if (rst) begin
        act = 1'b0; ma = '0; mb = '0; my = '0; mc = 1'b0; mz = 1'b0;
      end else begin
        idle0 = !act;
        if (act) begin
          d++;
          if (leg && d == EC) begin
            res = alu_ref(ma, mb, mo);
            my = res[3:0];
            mc = res[4];
            mz = res[3:0] == 4'd0;
          end
          if (leg ? d > EC : d > 0) act = 1'b0;
        end
        if (idle0 && start) begin
          act = 1'b1;
          d = 0;
          leg = opcode < 3'd5;
          if (leg) begin
            ma = a; mb = b; mo = opcode;
          end
        end
      end
    end
  end

  initial begin
    check("ref add carry", 23'(alu_ref(4'b1001, 4'b1000, 3'd3)), 23'(5'b10001));
    check("ref sub borrow", 23'(alu_ref(4'b0011, 4'b0101, 3'd4)), 23'(5'b11110));
    step(2);
    rst = 1'b0; start = 1'b0;
    step(1);
    for (int g = 0; g < 3; g++) check($sformatf("reset u%0d", g), obs[g], 23'd0);
    a = 4'b1010; b = 4'b0101; opcode = 3'd1; start = 1'b1;
    step(1);
    start = 1'b0;
    check("or_en k", 23'(obs[0][14:9]), 23'(6'b010000));
    step(1);
    check("or done k+1", 23'(obs[0][2:0]), 23'(3'b110));
    step(6);
    for (int g = 0; g < 3; g++) check($sformatf("or y u%0d", g), 23'(obs[g][8:3]), 23'(6'b111100));
    a = 4'b1001; b = 4'b1000; opcode = 3'd3; start = 1'b1;
    step(1);
    start = 1'b0;
    step(7);
    for (int g = 0; g < 3; g++) check($sformatf("add y u%0d", g), 23'(obs[g][8:3]), 23'(6'b000110));
    a = 4'b1100; b = 4'b0011; opcode = 3'd0; start = 1'b1;
    step(1);
    start = 1'b0;
    step(7);
    for (int g = 0; g < 3; g++) check($sformatf("and zero u%0d", g), 23'(obs[g][8:3]), 23'(6'b000001));
    opcode = 3'd7; start = 1'b1;
    step(1);
    start = 1'b0;
    for (int g = 0; g < 3; g++) check($sformatf("illegal u%0d", g), 23'(obs[g][14:0]), 23'(15'b000000_0000_0_1_1_1_1));
    step(1);
    for (int g = 0; g < 3; g++) check($sformatf("illegal idle u%0d", g), 23'(obs[g][2:0]), 23'd0);
    a = 4'b0110; b = 4'b0011; opcode = 3'd2; start = 1'b1;
    step(1);
    a = 4'b1111; b = 4'b1111; opcode = 3'd3;
    step(1);
    start = 1'b0;
    step(6);
    for (int g = 0; g < 3; g++) check($sformatf("busy ignore u%0d", g), 23'(obs[g][8:3]), 23'(6'b010100));
    check("busy oa", 23'(obs[2][22:19]), 23'(4'b0110));
    a = 4'b1111; b = 4'b1111; opcode = 3'd0; start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int g = 0; g < 3; g++) check($sformatf("mid reset u%0d", g), obs[g], 23'd0);
    step(6);
    check("mid reset quiet", obs[2], 23'd0);
    for (int i = 0; i < 600; i++) begin
      step(1);
      rst = $urandom_range(63) == 0;
      start = $urandom_range(2) == 0;
      opcode = 3'($urandom_range(7));
      a = 4'($urandom_range(15));
      b = 4'($urandom_range(15));
    end
    rst = 1'b0; start = 1'b0;
    step(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
